// File: rtl/led_cpu_core.sv
// Accumulator-style 8-register core with req/ack instruction fetch, carry/zero flags,
// HALT/resume and a divided LED-matrix row scanner. Optional DEBUG_REGS_EN adds dbg_regs/dbg_state.
module led_cpu_core #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 11,
    parameter int SCAN_DIV_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    input  logic              resume,
    output logic              halted,
    output logic              c_flag,
    output logic              z_flag,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] row,
`ifdef DEBUG_REGS_EN
    output logic [8*DATA_W-1:0] dbg_regs,
    output logic [1:0]          dbg_state,
`endif
    output logic [7:0]        col
);

    // Handshake: a fetch completes on a cycle where imem_req && imem_ack are both high;
    // imem_req stays high (with imem_addr stable) until that cycle, ack alone is ignored.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t              state, state_next;
    logic                req_en;
    logic [15:0]         ir;
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   regs [8];
    logic [SCAN_DIV_W+2:0] scan_cnt;

    logic [4:0]          op;
    logic [2:0]          rd_idx, rs_idx;
    logic [7:0]          imm;
    logic [DATA_W-1:0]   rd_val, rs_val;
    logic [DATA_W-1:0]   alu_res;
    logic                reg_we, c_next, z_next;
    logic [PC_W-1:0]     pc_next, imm_pc;
    logic                fetch_done;
    logic [2:0]          scan_idx;
    logic [DATA_W-1:0]   scan_reg;

    assign op     = ir[15:11];
    assign rd_idx = ir[10:8];
    assign rs_idx = ir[2:0];
    assign imm    = ir[7:0];
    assign rd_val = regs[rd_idx];
    assign rs_val = regs[rs_idx];
    assign imm_pc = PC_W'(imm);

    // req_en keeps imem_req low while in reset and raises it from the first clock after release.
    assign imem_req   = req_en && (state == FETCH);
    assign imem_addr  = pc;
    assign halted     = (state == HALT);
    assign fetch_done = imem_req && imem_ack;

    always_comb begin
        state_next = state;
        case (state)
            FETCH: if (fetch_done) state_next = EXEC;
            EXEC:  state_next = (op == 5'd16) ? HALT : FETCH;
            HALT:  if (resume) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        alu_res = '0;
        reg_we  = 1'b0;
        c_next  = c_flag;
        z_next  = z_flag;
        pc_next = pc + 1'b1;
        case (op)
            5'd1:  begin alu_res = rs_val;          reg_we = 1'b1; end
            5'd2:  begin alu_res = DATA_W'(imm);    reg_we = 1'b1; end
            5'd3:  begin {c_next, alu_res} = {1'b0, rd_val} + {1'b0, rs_val}; reg_we = 1'b1; end
            5'd4:  begin alu_res = rd_val - rs_val; c_next = (rd_val < rs_val); reg_we = 1'b1; end
            5'd5:  begin alu_res = rd_val & rs_val; reg_we = 1'b1; end
            5'd6:  begin alu_res = rd_val | rs_val; reg_we = 1'b1; end
            5'd7:  begin alu_res = rd_val ^ rs_val; reg_we = 1'b1; end
            5'd8:  begin alu_res = ~rd_val;         reg_we = 1'b1; end
            5'd9:  begin alu_res = rd_val + 1'b1;   c_next = &rd_val; reg_we = 1'b1; end
            5'd10: begin alu_res = {rd_val[0], rd_val[DATA_W-1:1]}; reg_we = 1'b1; end
            5'd11: begin alu_res = {rd_val[DATA_W-2:0], rd_val[DATA_W-1]}; reg_we = 1'b1; end
            5'd12: pc_next = imm_pc;
            5'd13: begin if (!c_flag) pc_next = imm_pc; c_next = 1'b0; end
            5'd14: begin if (c_flag) pc_next = imm_pc; c_next = 1'b0; end
            5'd15: if (z_flag) pc_next = imm_pc;
            // HALT keeps pc on its own address; resume advances it.
            5'd16: pc_next = pc;
            default: ;
        endcase
        if (op >= 5'd3 && op <= 5'd11) z_next = (alu_res == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            req_en <= 1'b0;
            ir     <= '0;
            pc     <= '0;
            pc_out <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state  <= state_next;
            req_en <= 1'b1;
            if (state == FETCH && fetch_done) ir <= imem_data;
            if (state == EXEC) begin
                if (reg_we) regs[rd_idx] <= alu_res;
                c_flag <= c_next;
                z_flag <= z_next;
                pc     <= pc_next;
                pc_out <= pc;
            end
            if (state == HALT && resume) pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) scan_cnt <= '0;
        else        scan_cnt <= scan_cnt + 1'b1;
    end

    assign scan_idx = scan_cnt[SCAN_DIV_W+2 -: 3];
    assign scan_reg = regs[scan_idx];
    assign col      = ~(8'h80 >> scan_idx);

    always_comb begin
        row = '0;
        for (int i = 0; i < DATA_W; i++) row[i] = scan_reg[DATA_W-1-i];
    end

`ifdef DEBUG_REGS_EN
    always_comb begin
        dbg_regs = '0;
        for (int k = 0; k < 8; k++) dbg_regs[k*DATA_W +: DATA_W] = regs[k];
    end
    assign dbg_state = state;
`endif

endmodule
